// File: rtl/dkong_wav_mixer.sv
// dkong_wav_mixer
// Wave-sample / music-DAC mixer for the Donkey Kong audio back-end.
// Once per sample period the ROM byte and the music DAC byte are captured,
// converted from offset binary to signed, weighted, summed, passed through a
// one-pole low-pass filter and saturated to a signed 16-bit output word.
// The sample counter must run in phase with the wave address generator's
// divider, so both are released from the same reset event.

module dkong_wav_mixer #(
    parameter int         SAMPLE_CNT = 2228,  // clocks per sample period
    parameter int         CAP_PT     = 1114,  // counter value at which inputs are captured
    parameter logic [3:0] WAV_W      = 4'd3,  // wave sample weight
    parameter logic [3:0] DAC_W      = 4'd5,  // music DAC weight
    parameter int         FILT_SHIFT = 2      // low-pass coefficient, 0 = pass-through
) (
    input  logic               I_CLK,
    input  logic               I_RST,
    input  logic [7:0]         I_ROM_DB,
    input  logic [7:0]         I_DAC,
    input  logic               I_MUTE,
    output logic signed [15:0] O_SOUND,
    output logic               O_SAMPLE_STB
);

    localparam logic [11:0] CNT_LAST = 12'(SAMPLE_CNT - 1);
    localparam logic [11:0] CNT_CAP  = 12'(CAP_PT);

    // Weights as non-negative signed operands so the multiply stays signed.
    localparam logic signed [12:0] WAV_W_S = 13'($signed({1'b0, WAV_W}));
    localparam logic signed [12:0] DAC_W_S = 13'($signed({1'b0, DAC_W}));

    // Saturation limits expressed at the filter state width.
    localparam logic signed [17:0] SAT_HI = 18'sd32767;
    localparam logic signed [17:0] SAT_LO = -18'sd32768;

    logic [11:0]        cnt;
    logic signed [7:0]  wav_s;
    logic signed [7:0]  dac_s;
    logic               cap_v;
    logic signed [12:0] sum;
    logic               sum_v;
    logic signed [17:0] y;
    logic               y_v;

    logic signed [12:0] wav_p;
    logic signed [12:0] dac_p;
    logic signed [16:0] x;
    logic signed [18:0] d;
    logic signed [17:0] d_sh;
    logic signed [17:0] y_next;
    logic signed [15:0] sat_val;

    // Sample counter: free-running 0..SAMPLE_CNT-1, phase-locked to the generator.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 12'd1;
        end
    end

    // Capture: sample both bytes mid-period, offset binary to two's complement.
    // NOTE: the datapath registers are reset too, so an in-flight sample is
    // dropped and the output reads silence immediately on reset.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            wav_s <= '0;
            dac_s <= '0;
            cap_v <= 1'b0;
        end else begin
            cap_v <= (cnt == CNT_CAP);
            if (cnt == CNT_CAP) begin
                wav_s <= $signed(I_ROM_DB ^ 8'h80);
                dac_s <= $signed(I_DAC ^ 8'h80);
            end
        end
    end

    // Weighted products; |sum| <= 3840, so 13 bits never overflow.
    assign wav_p = 13'(wav_s) * WAV_W_S;
    assign dac_p = 13'(dac_s) * DAC_W_S;

    // Stage 1: weighted sum, with mute forcing the filter input to silence.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            sum   <= '0;
            sum_v <= 1'b0;
        end else begin
            sum_v <= cap_v;
            if (cap_v) begin
                sum <= I_MUTE ? 13'sd0 : (wav_p + dac_p);
            end
        end
    end

    // Filter step: y += (x - y) >>> FILT_SHIFT, arithmetic shift floors toward -inf.
    assign x      = {sum, 4'b0000};
    assign d      = 19'(x) - 19'(y);
    assign d_sh   = 18'(d >>> FILT_SHIFT);
    assign y_next = y + d_sh;

    // Stage 2: one-pole low-pass state update.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            y   <= '0;
            y_v <= 1'b0;
        end else begin
            y_v <= sum_v;
            if (sum_v) begin
                y <= y_next;
            end
        end
    end

    // Clamp the 18-bit filter state into the signed 16-bit output range.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sat_val = y[15:0];
        if (y > SAT_HI) begin
            sat_val = 16'sh7FFF;
        end else if (y < SAT_LO) begin
            sat_val = 16'sh8000;
        end
    end

    // Stage 3: register the saturated word and pulse the strobe for one cycle.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            O_SOUND      <= '0;
            O_SAMPLE_STB <= 1'b0;
        end else begin
            O_SAMPLE_STB <= y_v;
            if (y_v) begin
                O_SOUND <= sat_val;
            end
        end
    end

endmodule
